sigma_delta_dac: RTL and testbench

Multi-channel, parametrised pulse-density DAC. It accepts frames of unsigned samples (one per channel) over a valid/ready stream and holds each frame for a programmable number of clocks. Each frame drives one first- or second-order sigma-delta modulator per channel, producing a 1-bit output per channel per clock. It sits between the audio/sample pipeline and the output pins, replacing the fixed single-channel first-order PDM.

---
 rtl/sigma_delta_dac.sv | 101 ++++++++++
 tb/tb_sigma_delta_dac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: multi-channel first/second-order sigma-delta PDM with a single-entry frame buffer
module sigma_delta_dac #(
  parameter int CHANNELS    = 2,
  parameter int INPUT_WIDTH = 16,
  parameter int OSR_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [OSR_WIDTH-1:0]            osr,
  input  logic                            order,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] s_data,
  output logic [CHANNELS-1:0]             dac_out,
  output logic                            frame_strobe,
  output logic                            underrun
);
  localparam int W  = INPUT_WIDTH;
  localparam int IW = W + 4;
  localparam int XW = W + 6;
  localparam logic signed [XW-1:0] HI = XW'((1 << (W + 2)) - 1);
  localparam logic signed [XW-1:0] LO = ~HI;
  logic                    buf_full;
  logic [CHANNELS*W-1:0]   buffer;
  logic [CHANNELS*W-1:0]   hold;
  logic [OSR_WIDTH-1:0]    cnt;
  logic [OSR_WIDTH-1:0]    osr_q;
  logic                    order_q;
  logic                    boundary;
  logic                    accept;
  logic                    clear;
  always_comb begin
    boundary = cnt == osr_q;
    accept   = s_valid && !buf_full;
    clear    = boundary && (order != order_q);
  end
  assign s_ready = !buf_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full     <= 1'b0;
      buffer       <= '0;
      hold         <= '0;
      cnt          <= '0;
      osr_q        <= osr;
      order_q      <= order;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 1'b1;
      frame_strobe <= boundary;
      underrun     <= boundary && !buf_full;
      buf_full     <= accept || (buf_full && !boundary);
      if (accept)
        buffer <= s_data;
      if (boundary) begin
        osr_q   <= osr;
        order_q <= order;
        if (buf_full)
          hold <= buffer;
      end
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : ch
    logic [W-1:0]           h;
    logic [W-1:0]           acc;
    logic [W:0]             s1;
    logic signed [IW-1:0]   i1;
    logic signed [IW-1:0]   i2;
    logic signed [IW-1:0]   i1n;
    logic signed [IW-1:0]   i2n;
    logic signed [XW-1:0]   fb;
    logic signed [XW-1:0]   t1;
    logic signed [XW-1:0]   t2;
    logic                   d;
    assign h          = hold[c*W +: W];
    assign dac_out[c] = d;
    always_comb begin
      s1  = {1'b0, acc} + {1'b0, h};
      fb  = d ? (XW'(1) << W) : '0;
      t1  = XW'(i1) + XW'({1'b0, h}) - fb;
      i1n = t1 > HI ? HI[IW-1:0] : t1 < LO ? LO[IW-1:0] : t1[IW-1:0];
      t2  = XW'(i2) + XW'(i1n) - fb;
      i2n = t2 > HI ? HI[IW-1:0] : t2 < LO ? LO[IW-1:0] : t2[IW-1:0];
    end
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        acc <= '0;
        i1  <= '0;
        i2  <= '0;
        d   <= 1'b0;
      end else if (!order_q) begin
        acc <= s1[W-1:0];
        d   <= s1[W];
      end else begin
        i1 <= i1n;
        i2 <= i2n;
        d  <= i2n > 0;
      end
    end
  end
endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb_sigma_delta_dac: directed scoreboard bench for sigma_delta_dac at W=8, two channels
module tb_sigma_delta_dac;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  osr = 8'd3;
  logic        order = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [1:0]  dac_out;
  logic        frame_strobe;
  logic        underrun;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  sigma_delta_dac #(.CHANNELS(2), .INPUT_WIDTH(8), .OSR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .osr(osr), .order(order), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .dac_out(dac_out),
    .frame_strobe(frame_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_strobe && n < 64);
    push(1);
    check("strobe_seen", 32'(frame_strobe));
  endtask

  task automatic wait_load();
    int n;
    int t;
    t = 0;
    do begin
      wait_strobe(n);
      t++;
    end while (underrun && t < 8);
    push(0);
    check("load_no_underrun", 32'(underrun));
  endtask

  task automatic count(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (n) begin
      step();
      c0 += int'(dac_out[0]);
      c1 += int'(dac_out[1]);
    end
  endtask

  task automatic send(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    int c0;
    int c1;
    @(negedge clk);
    step();
    step();
    push(0); check("rst_dac", 32'(dac_out));
    push(0); check("rst_strobe", 32'(frame_strobe));
    push(0); check("rst_underrun", 32'(underrun));
    push(1); check("rst_ready", 32'(s_ready));
    reset = 1'b0;
    send(16'h8080);
    wait_load();
    push(0); check("fo_half_load", 32'(dac_out));
    for (int k = 1; k <= 8; k++) begin
      push((k % 2 == 0) ? 3 : 0);
      step();
      check("fo_half_seq", 32'(dac_out));
    end
    count(256, c0, c1);
    push(128); check("fo_half_ch0", 32'(c0));
    push(128); check("fo_half_ch1", 32'(c1));
    send(16'hFF40);
    wait_load();
    count(256, c0, c1);
    push(64);  check("fo_exact_ch0", 32'(c0));
    push(255); check("fo_exact_ch1", 32'(c1));
    order = 1'b1;
    send(16'h00C0);
    wait_load();
    count(16, c0, c1);
    count(4096, c0, c1);
    push(1); check("so_density_ch0", 32'(c0 >= 3031 && c0 <= 3113));
    push(0); check("so_zero_ch1", 32'(c1));
    order = 1'b0;
    wait_strobe(n);
    push(0); check("switch_clear", 32'(dac_out));
    for (int k = 1; k <= 4; k++) begin
      push((k == 1) ? 0 : 1);
      step();
      check("switch_seq", 32'(dac_out));
    end
    osr = 8'd7;
    wait_strobe(n);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 8; k++) begin
        step();
        push(32'(k == 8)); check("ur_strobe", 32'(frame_strobe));
        push(32'(k == 8)); check("ur_pulse", 32'(underrun));
      end
    end
    count(256, c0, c1);
    push(192); check("ur_hold_ch0", 32'(c0));
    push(0);   check("ur_hold_ch1", 32'(c1));
    wait_strobe(n);
    repeat (7) step();
    send(16'hFF00);
    push(1); check("hb_underrun", 32'(underrun));
    push(1); check("hb_strobe", 32'(frame_strobe));
    push(0); check("hb_ready", 32'(s_ready));
    for (int k = 1; k <= 7; k++) begin
      step();
      push(0); check("hb_ready_hold", 32'(s_ready));
      push(0); check("hb_no_strobe", 32'(frame_strobe));
    end
    step();
    push(1); check("hb_load_strobe", 32'(frame_strobe));
    push(0); check("hb_load_underrun", 32'(underrun));
    push(1); check("hb_load_ready", 32'(s_ready));
    count(256, c0, c1);
    push(0);   check("hb_ch0", 32'(c0));
    push(255); check("hb_ch1", 32'(c1));
    wait_strobe(n);
    send(16'h5555);
    push(0); check("rs_full", 32'(s_ready));
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(1); check("rs_ready", 32'(s_ready));
    push(0); check("rs_dac", 32'(dac_out));
    push(0); check("rs_strobe", 32'(frame_strobe));
    push(0); check("rs_underrun", 32'(underrun));
    for (int k = 1; k <= 7; k++) begin
      step();
      push(0); check("rs_quiet", 32'({dac_out, frame_strobe, underrun}));
    end
    step();
    push(1); check("rs_first_strobe", 32'(frame_strobe));
    push(1); check("rs_discarded", 32'(underrun));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
